// File: rtl/audio_tone_pkg.sv
// Shared types and constants for the stereo test-tone source.
package audio_tone_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE  = 2'd0,
    WAVE_SAW     = 2'd1,
    WAVE_TRI     = 2'd2,
    WAVE_SILENCE = 2'd3
  } wave_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/audio_tone_wave.sv
// Combinational shaper: phase + waveform select + volume shift -> signed 16-bit sample.
module audio_tone_wave
  import audio_tone_pkg::*;
#(
  parameter int          PHASE_W = 24,
  parameter logic [15:0] AMP     = 16'h4000
) (
  input  logic [PHASE_W-1:0] phase_i,
  input  logic [1:0]         waveform_i,
  input  logic [3:0]         volume_i,
  output logic [15:0]        sample_o
);

  wave_e              wave;
  logic               msb;
  logic [14:0]        fold;
  logic [14:0]        tri_u;
  logic signed [15:0] raw;
  logic               unused_low;

  assign wave       = wave_e'(waveform_i);
  assign msb        = phase_i[PHASE_W-1];
  assign fold       = phase_i[PHASE_W-2 -: 15];
  assign tri_u      = msb ? ~fold : fold;
  assign unused_low = ^phase_i[PHASE_W-17:0];

  // NOTE: raw gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    raw = '0;
    case (wave)
      WAVE_SQUARE:  raw = msb ? -AMP : AMP;
      WAVE_SAW:     raw = phase_i[PHASE_W-1 -: 16] ^ 16'h8000;
      WAVE_TRI:     raw = {tri_u, 1'b0} ^ 16'h8000;
      WAVE_SILENCE: raw = '0;
      default:      raw = '0;
    endcase
  end

  // Arithmetic shift keeps the sign, so full attenuation settles at 0 or -1.
  assign sample_o = raw >>> volume_i;

endmodule

// File: rtl/audio_tone_source.sv
// Stereo test-tone source feeding the codec's left/right Avalon-ST sinks in lockstep.
// Optional LSB dither from a 16-bit LFSR is built when AUDIO_TONE_DITHER_EN is defined.
module audio_tone_source
  import audio_tone_pkg::*;
#(
  parameter int          PHASE_W = 24,
  parameter logic [15:0] AMP     = 16'h4000
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               enable,
  input  logic [PHASE_W-1:0] tune_word,
  input  logic [1:0]         waveform,
  input  logic [3:0]         volume,
  output logic [15:0]        left_data,
  output logic [15:0]        right_data,
  output logic               left_valid,
  output logic               right_valid,
  input  logic               left_ready,
  input  logic               right_ready,
  output logic [15:0]        pair_count
);

  state_e             state_q;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [15:0]        left_data_q, right_data_q, pair_count_q;
  logic               left_valid_q, right_valid_q;
  logic               pair_done;
  logic [PHASE_W-1:0] sample_phase;
  logic [15:0]        sample, left_sample, right_sample;

  // A channel whose valid already dropped has completed; the pair is done once both have.
  assign pair_done    = (state_q == ST_ISSUE) &&
                        (!left_valid_q  || left_ready) &&
                        (!right_valid_q || right_ready);
  assign phase_d      = phase_q + tune_word;
  assign sample_phase = pair_done ? phase_d : phase_q;

  audio_tone_wave #(
    .PHASE_W (PHASE_W),
    .AMP     (AMP)
  ) u_wave (
    .phase_i    (sample_phase),
    .waveform_i (waveform),
    .volume_i   (volume),
    .sample_o   (sample)
  );

`ifdef AUDIO_TONE_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = pair_done ? lfsr_step(lfsr_q) : lfsr_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) lfsr_q <= LFSR_SEED;
    else                lfsr_q <= lfsr_d;
  end

  // The sample being loaded carries the LFSR value it will be presented with.
  assign left_sample  = sample ^ {15'd0, lfsr_d[0]};
  assign right_sample = sample ^ {15'd0, lfsr_d[1]};
`else
  assign left_sample  = sample;
  assign right_sample = sample;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      left_data_q   <= '0;
      right_data_q  <= '0;
      left_valid_q  <= 1'b0;
      right_valid_q <= 1'b0;
      pair_count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            left_data_q   <= left_sample;
            right_data_q  <= right_sample;
            left_valid_q  <= 1'b1;
            right_valid_q <= 1'b1;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (pair_done) begin
            phase_q      <= phase_d;
            pair_count_q <= pair_count_q + 16'd1;
            if (enable) begin
              left_data_q   <= left_sample;
              right_data_q  <= right_sample;
              left_valid_q  <= 1'b1;
              right_valid_q <= 1'b1;
            end else begin
              left_valid_q  <= 1'b0;
              right_valid_q <= 1'b0;
              state_q       <= ST_IDLE;
            end
          end else begin
            if (left_valid_q && left_ready)   left_valid_q  <= 1'b0;
            if (right_valid_q && right_ready) right_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign left_data   = left_data_q;
  assign right_data  = right_data_q;
  assign left_valid  = left_valid_q;
  assign right_valid = right_valid_q;
  assign pair_count  = pair_count_q;

endmodule

// File: tb/tb_audio_tone_source.sv
// Directed bench for audio_tone_source: square, saw handshake, enable drop, reset, triangle, silence.
`timescale 1ns/1ps
module tb_audio_tone_source;

  localparam int PHASE_W = 24;
`ifdef AUDIO_TONE_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  logic               clk_clk       = 1'b0;
  logic               reset_reset_n = 1'b0;
  logic               enable        = 1'b0;
  logic [PHASE_W-1:0] tune_word     = '0;
  logic [1:0]         waveform      = '0;
  logic [3:0]         volume        = '0;
  logic               left_ready    = 1'b0;
  logic               right_ready   = 1'b0;
  logic [15:0]        left_data, right_data, pair_count;
  logic               left_valid, right_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_pc   = 0;

  logic [15:0] tri_tbl [8] = '{16'hC000, 16'hE000, 16'h0000, 16'h2000,
                               16'h3FFF, 16'h1FFF, 16'hFFFF, 16'hDFFF};

  always #5 clk_clk = ~clk_clk;

  audio_tone_source #(.PHASE_W(PHASE_W), .AMP(16'h4000)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .enable        (enable),
    .tune_word     (tune_word),
    .waveform      (waveform),
    .volume        (volume),
    .left_data     (left_data),
    .right_data    (right_data),
    .left_valid    (left_valid),
    .right_valid   (right_valid),
    .left_ready    (left_ready),
    .right_ready   (right_ready),
    .pair_count    (pair_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] x;
    x = 16'hACE1;
    for (int i = 0; i < n; i++) x = {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
    return x;
  endfunction

  function automatic logic [15:0] exp_data(input logic [15:0] base, input int n, input bit right);
    logic [15:0] x;
    x = lfsr_at(n);
    return base ^ {15'd0, (right ? x[1] : x[0]) & DITHER};
  endfunction

  task automatic pair_check(input string tag, input logic [15:0] base);
    check({tag, "_lvalid"}, 16'(left_valid), 16'd1);
    check({tag, "_rvalid"}, 16'(right_valid), 16'd1);
    check({tag, "_ldata"}, left_data, exp_data(base, exp_pc, 1'b0));
    check({tag, "_rdata"}, right_data, exp_data(base, exp_pc, 1'b1));
    check({tag, "_count"}, pair_count, 16'(exp_pc));
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_lvalid"}, 16'(left_valid), 16'd0);
    check({tag, "_rvalid"}, 16'(right_valid), 16'd0);
    check({tag, "_count"}, pair_count, 16'(exp_pc));
  endtask

  initial begin
    repeat (2) @(negedge clk_clk);
    idle_check("reset");
    check("reset_ldata", left_data, 16'h0000);
    check("reset_rdata", right_data, 16'h0000);
    reset_reset_n = 1'b1;

    // Square, both readys high: one pair per clock after the first.
    tune_word = 24'h100000; waveform = 2'd0; volume = 4'd0;
    left_ready = 1'b1; right_ready = 1'b1; enable = 1'b1;
    @(negedge clk_clk);
    for (int i = 0; i < 16; i++) begin
      pair_check("square", (i < 8) ? 16'h4000 : 16'hC000);
      if (i == 15) enable = 1'b0;
      @(negedge clk_clk);
      exp_pc++;
    end
    idle_check("square_end");

    // Saw with right ready only every third cycle.
    waveform = 2'd1; right_ready = 1'b0; enable = 1'b1;
    @(negedge clk_clk);
    for (int k = 0; k < 16; k++) begin
      pair_check("saw", 16'(k * 16'h1000) ^ 16'h8000);
      @(negedge clk_clk);
      check("saw_ldrop", 16'(left_valid), 16'd0);
      check("saw_rwait", 16'(right_valid), 16'd1);
      check("saw_rhold", right_data, exp_data(16'(k * 16'h1000) ^ 16'h8000, exp_pc, 1'b1));
      @(negedge clk_clk);
      check("saw_lnoreissue", 16'(left_valid), 16'd0);
      right_ready = 1'b1;
      @(negedge clk_clk);
      right_ready = 1'b0;
      exp_pc++;
    end

    // Enable drop with both readys low: the pending pair must hold, then finish.
    left_ready = 1'b0; enable = 1'b0;
    pair_check("saw_wrap", 16'h8000);
    @(negedge clk_clk);
    pair_check("drop_hold1", 16'h8000);
    @(negedge clk_clk);
    pair_check("drop_hold2", 16'h8000);
    left_ready = 1'b1; right_ready = 1'b1;
    @(negedge clk_clk);
    exp_pc++;
    idle_check("drop_idle");
    repeat (2) @(negedge clk_clk);
    idle_check("drop_idle_stay");
    left_ready = 1'b0; right_ready = 1'b0; enable = 1'b1;
    @(negedge clk_clk);
    pair_check("phase_frozen", 16'h9000);

    // Asynchronous reset in the middle of a pending pair.
    #2 reset_reset_n = 1'b0;
    #1;
    exp_pc = 0;
    idle_check("async_rst");
    check("async_rst_ldata", left_data, 16'h0000);
    check("async_rst_rdata", right_data, 16'h0000);
    @(negedge clk_clk);
    waveform = 2'd2; tune_word = 24'h200000; volume = 4'd1;
    left_ready = 1'b1; right_ready = 1'b1; enable = 1'b1;
    reset_reset_n = 1'b1;
    @(negedge clk_clk);

    // Triangle at half volume, restarting from phase 0.
    for (int i = 0; i < 8; i++) begin
      pair_check("tri", tri_tbl[i]);
      @(negedge clk_clk);
      exp_pc++;
    end
    waveform = 2'd3; volume = 4'd0;
    pair_check("tri_wrap", 16'hC000);
    @(negedge clk_clk);
    exp_pc++;

    // Silence keeps pacing; then square at full attenuation gives -1 / 0.
    for (int i = 0; i < 4; i++) begin
      pair_check("silence", 16'h0000);
      if (i == 3) begin
        waveform = 2'd0;
        volume   = 4'd15;
      end
      @(negedge clk_clk);
      exp_pc++;
    end
    for (int i = 0; i < 4; i++) begin
      pair_check("vol15", (i == 3) ? 16'h0000 : 16'hFFFF);
      if (i == 3) enable = 1'b0;
      @(negedge clk_clk);
      exp_pc++;
    end
    idle_check("final_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_tone_source.md
# audio_tone_source

Stereo test-tone generator that sits directly upstream of the audio codec core and drives its left and right Avalon-ST channel sinks (16-bit data/valid/ready). A phase accumulator produces square, sawtooth or triangle samples. The codec core's ready signals set the pace. Left and right receive identical sample pairs in lockstep, one pair per phase step, so board bring-up and loopback checks need no CPU.

## Interface
- PHASE_W, 24, phase accumulator width (≥17)
- AMP, 16'h4000, square-wave magnitude (positive, ≤16'h7FFF)
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- enable  in  1  run tone; 0 = finish current pair then idle
- tune_word  in  PHASE_W  phase increment, sampled at each pair completion
- waveform  in  2  0 square, 1 saw, 2 triangle, 3 silence
- volume  in  4  arithmetic right-shift applied to sample
- left_data / right_data  out  16  signed sample to codec sinks
- left_valid / right_valid  out  1  Avalon-ST valid
- left_ready / right_ready  in  1  Avalon-ST ready from codec sinks
- pair_count  out  16  completed pairs, wraps at 16'hFFFF→0

Decided: one clock `clk_clk`; reset `reset_reset_n` is asynchronous, active-low.

## Operation
- States: IDLE (valids 0), ISSUE (pair presented).
- IDLE→ISSUE when enable=1. Sample is computed from the current phase. Data is loaded and both valids rise the next cycle.
- In ISSUE, a channel completes on valid&ready. Its valid then drops and stays low until the pair completes. Data holds stable while its valid is high.
- Pair completes when both channels have completed, in either order or the same cycle. At that edge:
  - phase += tune_word, mod 2^PHASE_W
  - pair_count++
  - if enable=1, new data loads and both valids reassert next cycle (back-to-back, one pair per clock when both readys are held high)
  - else the block goes to IDLE
- Dropping enable never aborts a presented pair.
- waveform, volume and tune_word are sampled only when the sample is loaded.
- Shaping, with P = phase, M = P[PHASE_W-1]:
  - square: M=0 → +AMP, else −AMP
  - saw: P[PHASE_W-1 -:16] ^ 16'h8000
  - triangle: f = P[PHASE_W-2 -:15]; u = M ? ~f : f; sample = {u,1'b0} ^ 16'h8000
  - silence: 0. Pacing and pair_count still run.
- Volume: signed >>> volume, so 15 yields 0 or −1.

## Timing
- Reset: state IDLE, phase 0, both valids 0, both data 0, pair_count 0. No state needs clocking out of reset.
- Latency: enable rise → valids high 1 cycle later.
- Completion → next pair valid: 1 cycle.
- Reset asserted mid-pair: valids drop immediately (async). After release the block restarts from phase 0 and the pair is lost.
- Held readys low: valids and data hold indefinitely. No timeout.

## Configuration
- AUDIO_TONE_DITHER_EN defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 at reset, advances once per completed pair.
  - Left LSB ^= lfsr[0]; right LSB ^= lfsr[1], applied after the volume shift. Channels then differ in LSB only.
- Undefined: no LFSR, and left and right data are bit-identical.

## Structure
- Package audio_tone_pkg holds:
  - waveform enum (WAVE_SQUARE, WAVE_SAW, WAVE_TRI, WAVE_SILENCE)
  - state enum (ST_IDLE, ST_ISSUE)
  - LFSR seed and tap constants
- Sub-module audio_tone_wave: combinational phase+waveform+volume → 16-bit sample. The top level owns the FSM, phase register, handshakes, pair_count and LFSR.

## Test plan
- Square, basic run: readys held 1, tune_word 24'h100000, square, volume 0, dither off. Pairs 0–7 = 16'h4000, pairs 8–15 = 16'hC000, repeating. One pair per cycle after the first. pair_count = 16 after 16 pairs.
- Saw, staggered handshake: saw, same tune_word. Data goes 16'h8000, 16'h9000, … 16'h7000, then 16'h8000. Left ready 1; right ready high every 3rd cycle. Left valid drops after its accept and does not reissue until right accepts. Left and right sequences are identical.
- Triangle with volume: triangle, tune_word 24'h200000, volume 1. Samples 16'hC000, 16'hE000, 16'h0000, 16'h2000, 16'h3FFF, 16'h1FFF, 16'hFFFF, 16'hDFFF (check against the shaper formula).
- Enable drop: enable drops while a pair is pending with readys 0. Valids stay high. After both accept, the block goes to IDLE, valids are 0 and phase is frozen.
- Reset mid-pair: reset_reset_n pulses low mid-pair. Valids, data and pair_count go to 0 asynchronously. After release, the first pair is the phase-0 sample.
- Dither (AUDIO_TONE_DITHER_EN): silence waveform. Left/right LSBs follow LFSR bits 0/1 from seed 16'hACE1; upper bits are 0 (or all-ones where the LSB toggles through −1 is not expected). Without the macro, all samples are 0.
